// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Holds the FSM state encoding and the overflow rule.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sadd_state_t;

  function automatic logic ovf_calc(
    input logic c_msb_in,
    input logic c_out
  );
    return c_msb_in ^ c_out;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// master: producer+consumer side; slave: the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder.
// Ports: x, y, ci in; s, co, c_msb (carry into top bit) out.
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic cy;

  always_comb begin
    cy    = ci;
    c_msb = ci;
    s     = '0;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb = cy;
      s[i]  = x[i] ^ y[i] ^ cy;
      cy    = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    co = cy;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial two's-complement adder, DIGIT bits per clock.
// Ports: clk, reset_n, bus (slave: in/out valid-ready, a, b, cin, sum, cout, ovf).
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic           clk,
  input logic           reset_n,
  serial_adder_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad
    $error("serial_adder: DIGIT must divide WIDTH");
  end

  sadd_state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, ps_q, sum_q;
  logic             c_q, cout_q, ovf_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0]       ds;
  logic                   dco, dmsb;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]       ps_d;
  logic                   last, accept;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_dig (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .ci   (c_q),
    .s    (ds),
    .co   (dco),
    .c_msb(dmsb)
  );

  // New digit enters at the MSB; after NDIG steps digit 0 sits at bit 0.
  assign cat    = {ds, ps_q};
  assign ps_d   = cat[WIDTH+DIGIT-1:DIGIT];
  assign last   = (cnt_q == CW'(NDIG - 1));
  assign accept = bus.in_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      ps_q   <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      c_q   <= bus.cin;
      ps_q  <= '0;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      a_q  <= a_q >> DIGIT;
      b_q  <= b_q >> DIGIT;
      ps_q <= ps_d;
      c_q  <= dco;
      if (last) begin
        sum_q  <= ps_d;
        cout_q <= dco;
        ovf_q  <= ovf_calc(dmsb, dco);
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule
